// File: rtl/tl_bridge_arbiter.sv
// tl_bridge_arbiter
//   Shares one TileLink-UL-to-AXI4 bridge port among NM TileLink masters.
//   Only one transaction is in flight at a time. A master is granted, its A
//   beats are forwarded, and the bridge's D beats are routed back to that
//   master. The grant is released after the final D beat. The downstream
//   source is {grant index, upstream source}.
//
//   Optional build macro:
//     TL_ARB_FIXED_PRIO_EN - lowest-index requester always wins (ptr held 0);
//                            undefined gives round-robin.
//
// Ports
//   axi_aclk, axi_aresetn  clock, asynchronous active-low reset
//   up_a_*                 NM packed A channels from the masters (slice i = master i)
//   up_d_*                 NM packed D channels to the masters (fields broadcast,
//                          only up_d_valid is per master)
//   dn_a_*                 single A channel to the bridge
//   dn_d_*                 single D channel from the bridge
//   busy                   high whenever a transaction owns the bridge
module tl_bridge_arbiter #(
  parameter  int NM  = 2,
  parameter  int CAW = 28,
  parameter  int CDW = 32,
  parameter  int CIW = 4,
  localparam int BPB = CDW / 8,
  localparam int MIW = $clog2(NM)
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic [NM*3-1:0]      up_a_opcode,
  input  logic [NM*3-1:0]      up_a_param,
  input  logic [NM*4-1:0]      up_a_size,
  input  logic [NM*CIW-1:0]    up_a_source,
  input  logic [NM*CAW-1:0]    up_a_address,
  input  logic [NM*BPB-1:0]    up_a_mask,
  input  logic [NM*CDW-1:0]    up_a_data,
  input  logic [NM-1:0]        up_a_corrupt,
  input  logic [NM-1:0]        up_a_valid,
  output logic [NM-1:0]        up_a_ready,
  output logic [NM*3-1:0]      up_d_opcode,
  output logic [NM*2-1:0]      up_d_param,
  output logic [NM*4-1:0]      up_d_size,
  output logic [NM*CIW-1:0]    up_d_source,
  output logic [NM-1:0]        up_d_denied,
  output logic [NM*CDW-1:0]    up_d_data,
  output logic [NM-1:0]        up_d_corrupt,
  output logic [NM-1:0]        up_d_valid,
  input  logic [NM-1:0]        up_d_ready,
  output logic [2:0]           dn_a_opcode,
  output logic [2:0]           dn_a_param,
  output logic [3:0]           dn_a_size,
  output logic [CIW+MIW-1:0]   dn_a_source,
  output logic [CAW-1:0]       dn_a_address,
  output logic [BPB-1:0]       dn_a_mask,
  output logic [CDW-1:0]       dn_a_data,
  output logic                 dn_a_corrupt,
  output logic                 dn_a_valid,
  input  logic                 dn_a_ready,
  input  logic [2:0]           dn_d_opcode,
  input  logic [1:0]           dn_d_param,
  input  logic [3:0]           dn_d_size,
  input  logic [CIW+MIW-1:0]   dn_d_source,
  input  logic                 dn_d_denied,
  input  logic [CDW-1:0]       dn_d_data,
  input  logic                 dn_d_corrupt,
  input  logic                 dn_d_valid,
  output logic                 dn_d_ready,
  output logic                 busy
);

  localparam int BPB_LG = $clog2(BPB);

  typedef logic [15:0] cnt_t;
  typedef enum logic [1:0] {IDLE, A_PHASE, D_PHASE} state_t;

  state_t           state_q, state_d;
  logic [MIW-1:0]   grant_q, ptr_q;
  cnt_t             a_cnt_q, d_cnt_q;

  logic [NM-1:0]    req_rot;
  logic [MIW:0]     sel_sum;
  logic [MIW-1:0]   sel_idx;
  logic             sel_found;
  logic [2:0]       sel_opcode;
  logic [3:0]       sel_size;
  logic             g_a_valid, g_d_ready;
  logic [CIW-1:0]   g_source;
  logic             a_hs, d_hs;
  logic             unused_d_idx;

  // Bytes per request rounded up to whole beats; BPB is a power of two.
  function automatic cnt_t beats(input logic [3:0] sz);
    logic [16:0] bytes;
    bytes = 17'd1 << sz;
    if (bytes <= 17'(BPB)) return cnt_t'(1);
    return cnt_t'(bytes >> BPB_LG);
  endfunction

  function automatic cnt_t a_beats(input logic [2:0] op, input logic [3:0] sz);
    return (op == 3'd0 || op == 3'd1) ? beats(sz) : cnt_t'(1);
  endfunction

  function automatic cnt_t d_beats(input logic [2:0] op, input logic [3:0] sz);
    return (op == 3'd4) ? beats(sz) : cnt_t'(1);
  endfunction

  // Rotate requests so bit 0 is the master at ptr; the lowest set bit wins.
  always_comb begin
    req_rot   = NM'({up_a_valid, up_a_valid} >> ptr_q);
    sel_found = 1'b0;
    sel_sum   = '0;
    for (int k = NM-1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sel_found = 1'b1;
        sel_sum   = {1'b0, ptr_q} + (MIW+1)'(k);
        if (sel_sum >= (MIW+1)'(NM)) sel_sum = sel_sum - (MIW+1)'(NM);
      end
    end
    sel_idx = sel_sum[MIW-1:0];
  end

  always_comb begin
    sel_opcode   = '0;
    sel_size     = '0;
    dn_a_opcode  = '0;
    dn_a_param   = '0;
    dn_a_size    = '0;
    g_source     = '0;
    dn_a_address = '0;
    dn_a_mask    = '0;
    dn_a_data    = '0;
    dn_a_corrupt = 1'b0;
    g_a_valid    = 1'b0;
    g_d_ready    = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (sel_idx == MIW'(i)) begin
        sel_opcode = up_a_opcode[i*3 +: 3];
        sel_size   = up_a_size[i*4 +: 4];
      end
      if (grant_q == MIW'(i)) begin
        dn_a_opcode  = up_a_opcode[i*3 +: 3];
        dn_a_param   = up_a_param[i*3 +: 3];
        dn_a_size    = up_a_size[i*4 +: 4];
        g_source     = up_a_source[i*CIW +: CIW];
        dn_a_address = up_a_address[i*CAW +: CAW];
        dn_a_mask    = up_a_mask[i*BPB +: BPB];
        dn_a_data    = up_a_data[i*CDW +: CDW];
        dn_a_corrupt = up_a_corrupt[i];
        g_a_valid    = up_a_valid[i];
        g_d_ready    = up_d_ready[i];
      end
    end
  end

  assign dn_a_source = {grant_q, g_source};
  assign dn_a_valid  = (state_q == A_PHASE) && g_a_valid;
  assign dn_d_ready  = (state_q == D_PHASE) && g_d_ready;
  assign a_hs        = dn_a_valid && dn_a_ready;
  assign d_hs        = dn_d_valid && dn_d_ready;
  assign busy        = (state_q != IDLE);

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      up_a_ready[i] = (state_q == A_PHASE) && (grant_q == MIW'(i)) && dn_a_ready;
      up_d_valid[i] = (state_q == D_PHASE) && (grant_q == MIW'(i)) && dn_d_valid;
    end
  end

  // D fields go to every master; only the granted master sees up_d_valid.
  // The index bits of dn_d_source are ignored: one transaction is outstanding.
  assign up_d_opcode  = {NM{dn_d_opcode}};
  assign up_d_param   = {NM{dn_d_param}};
  assign up_d_size    = {NM{dn_d_size}};
  assign up_d_source  = {NM{dn_d_source[CIW-1:0]}};
  assign up_d_denied  = {NM{dn_d_denied}};
  assign up_d_data    = {NM{dn_d_data}};
  assign up_d_corrupt = {NM{dn_d_corrupt}};
  assign unused_d_idx = ^dn_d_source[CIW+MIW-1:CIW];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = A_PHASE;
      A_PHASE: if (a_hs && a_cnt_q == cnt_t'(1)) state_d = D_PHASE;
      D_PHASE: if (d_hs && d_cnt_q == cnt_t'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      grant_q <= '0;
      ptr_q   <= '0;
      a_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (sel_found) begin
          grant_q <= sel_idx;
          a_cnt_q <= a_beats(sel_opcode, sel_size);
          d_cnt_q <= d_beats(sel_opcode, sel_size);
        end
        A_PHASE: if (a_hs) a_cnt_q <= a_cnt_q - cnt_t'(1);
        D_PHASE: if (d_hs) begin
          d_cnt_q <= d_cnt_q - cnt_t'(1);
`ifndef TL_ARB_FIXED_PRIO_EN
          if (d_cnt_q == cnt_t'(1))
            ptr_q <= (grant_q == MIW'(NM-1)) ? '0 : grant_q + MIW'(1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_bridge_arbiter.sv
// tb_tl_bridge_arbiter
//   Self-checking bench for tl_bridge_arbiter (NM=2, CDW=32). The bench plays
//   both the masters and the bridge. Expected D beats are queued when a request
//   is issued and are compared when the DUT hands a beat to a master.
module tb_tl_bridge_arbiter;
  localparam int NM = 2, CAW = 28, CDW = 32, CIW = 4, BPB = 4, MIW = 1;

  logic                axi_aclk = 1'b0;
  logic                axi_aresetn;
  logic [NM*3-1:0]     up_a_opcode, up_a_param;
  logic [NM*4-1:0]     up_a_size;
  logic [NM*CIW-1:0]   up_a_source;
  logic [NM*CAW-1:0]   up_a_address;
  logic [NM*BPB-1:0]   up_a_mask;
  logic [NM*CDW-1:0]   up_a_data;
  logic [NM-1:0]       up_a_corrupt, up_a_valid, up_a_ready;
  logic [NM*3-1:0]     up_d_opcode;
  logic [NM*2-1:0]     up_d_param;
  logic [NM*4-1:0]     up_d_size;
  logic [NM*CIW-1:0]   up_d_source;
  logic [NM-1:0]       up_d_denied, up_d_corrupt, up_d_valid, up_d_ready;
  logic [NM*CDW-1:0]   up_d_data;
  logic [2:0]          dn_a_opcode, dn_a_param;
  logic [3:0]          dn_a_size;
  logic [CIW+MIW-1:0]  dn_a_source;
  logic [CAW-1:0]      dn_a_address;
  logic [BPB-1:0]      dn_a_mask;
  logic [CDW-1:0]      dn_a_data;
  logic                dn_a_corrupt, dn_a_valid, dn_a_ready;
  logic [2:0]          dn_d_opcode;
  logic [1:0]          dn_d_param;
  logic [3:0]          dn_d_size;
  logic [CIW+MIW-1:0]  dn_d_source;
  logic                dn_d_denied, dn_d_corrupt, dn_d_valid, dn_d_ready;
  logic [CDW-1:0]      dn_d_data;
  logic                busy;

  tl_bridge_arbiter #(.NM(NM), .CAW(CAW), .CDW(CDW), .CIW(CIW)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .up_a_opcode(up_a_opcode), .up_a_param(up_a_param), .up_a_size(up_a_size),
    .up_a_source(up_a_source), .up_a_address(up_a_address), .up_a_mask(up_a_mask),
    .up_a_data(up_a_data), .up_a_corrupt(up_a_corrupt), .up_a_valid(up_a_valid),
    .up_a_ready(up_a_ready),
    .up_d_opcode(up_d_opcode), .up_d_param(up_d_param), .up_d_size(up_d_size),
    .up_d_source(up_d_source), .up_d_denied(up_d_denied), .up_d_data(up_d_data),
    .up_d_corrupt(up_d_corrupt), .up_d_valid(up_d_valid), .up_d_ready(up_d_ready),
    .dn_a_opcode(dn_a_opcode), .dn_a_param(dn_a_param), .dn_a_size(dn_a_size),
    .dn_a_source(dn_a_source), .dn_a_address(dn_a_address), .dn_a_mask(dn_a_mask),
    .dn_a_data(dn_a_data), .dn_a_corrupt(dn_a_corrupt), .dn_a_valid(dn_a_valid),
    .dn_a_ready(dn_a_ready),
    .dn_d_opcode(dn_d_opcode), .dn_d_param(dn_d_param), .dn_d_size(dn_d_size),
    .dn_d_source(dn_d_source), .dn_d_denied(dn_d_denied), .dn_d_data(dn_d_data),
    .dn_d_corrupt(dn_d_corrupt), .dn_d_valid(dn_d_valid), .dn_d_ready(dn_d_ready),
    .busy(busy)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { int m; logic [3:0] src; logic [2:0] op; } sb_t;
  sb_t sb[$];

  typedef struct {
    int m; logic [2:0] op; logic [3:0] sz; logic [3:0] src;
    int exp_a; int exp_d; int didx; bit tog; int stall; bit other;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input int m, input int op, input int sz, input int src,
                              input int ea, input int ed, input int didx = 0,
                              input bit tog = 1'b0, input int stall = 0, input bit other = 1'b0);
    vec_t v;
    v.m = m; v.op = 3'(op); v.sz = 4'(sz); v.src = 4'(src);
    v.exp_a = ea; v.exp_d = ed; v.didx = didx; v.tog = tog; v.stall = stall; v.other = other;
    return v;
  endfunction

  function automatic logic [31:0] exp_adata(input int m, input int beat);
    return 32'hA000_0000 | 32'(m << 8) | 32'(beat);
  endfunction
  function automatic logic [31:0] exp_ddata(input int beat);
    return 32'hD000_0000 | 32'(beat);
  endfunction
  function automatic logic [27:0] exp_addr(input int m);
    return 28'h100_0000 + 28'(m * 64);
  endfunction

  task automatic drive_a(input int m, input logic [2:0] op, input logic [3:0] sz,
                         input logic [3:0] src, input int beat);
    up_a_opcode[m*3 +: 3]       = op;
    up_a_param[m*3 +: 3]        = 3'd0;
    up_a_size[m*4 +: 4]         = sz;
    up_a_source[m*CIW +: CIW]   = src;
    up_a_address[m*CAW +: CAW]  = exp_addr(m);
    up_a_mask[m*BPB +: BPB]     = '1;
    up_a_data[m*CDW +: CDW]     = exp_adata(m, beat);
    up_a_corrupt[m]             = 1'b0;
  endtask

  // One complete transaction for master v.m; entered and left at posedge+1.
  task automatic run_txn(input vec_t v);
    int a_hs, d_hs, cyc, first_a, stall_left, o;
    sb_t e;
    a_hs = 0; d_hs = 0; cyc = 0; first_a = -1; stall_left = v.stall; o = 1 - v.m;
    for (int k = 0; k < v.exp_d; k++)
      sb.push_back('{m: v.m, src: v.src, op: (v.op == 3'd4) ? 3'd1 : 3'd0});
    drive_a(v.m, v.op, v.sz, v.src, 0);
    up_a_valid = '0;
    up_a_valid[v.m] = 1'b1;
    if (v.other) begin
      drive_a(o, 3'd4, 4'd2, 4'hE, 0);
      up_a_valid[o] = 1'b1;
    end
    dn_a_ready = 1'b1;
    up_d_ready = '0;
    up_d_ready[v.m] = 1'b1;
    dn_d_valid  = 1'b1;
    dn_d_opcode = (v.op == 3'd4) ? 3'd1 : 3'd0;
    dn_d_param  = 2'd0;
    dn_d_size   = v.sz;
    dn_d_source = {1'(v.didx), v.src};
    dn_d_data   = exp_ddata(0);
    while (d_hs < v.exp_d && cyc < 200) begin
      #1;
      if (a_hs < v.exp_a) check("d_blocked_in_a", {up_d_valid, dn_d_ready}, 0);
      if (cyc > 0) check("busy_during", busy, 1);
      if (v.other) check("other_ready", up_a_ready[o], 0);
      if (dn_a_valid && dn_a_ready) begin
        if (first_a < 0) first_a = cyc;
        check("a_source", dn_a_source, {1'(v.m), v.src});
        check("a_data", dn_a_data, exp_adata(v.m, a_hs));
        check("a_up_ready", up_a_ready[v.m], 1);
        if (a_hs == 0) begin
          check("a_addr", dn_a_address, exp_addr(v.m));
          check("a_size", dn_a_size, v.sz);
          check("a_opcode", dn_a_opcode, v.op);
        end
        a_hs++;
      end else if (a_hs > 0 && a_hs < v.exp_a && !up_a_valid[v.m]) begin
        check("stall_a_valid", dn_a_valid, 0);
      end
      if (|up_d_valid) check("d_onehot", up_d_valid, 1 << v.m);
      for (int i = 0; i < NM; i++) begin
        if (up_d_valid[i] && up_d_ready[i]) begin
          if (sb.size() == 0) check("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            check("d_master", i, e.m);
            check("d_source", up_d_source[i*CIW +: CIW], e.src);
            check("d_opcode", up_d_opcode[i*3 +: 3], e.op);
            check("d_data", up_d_data[i*CDW +: CDW], exp_ddata(d_hs));
          end
        end
      end
      if (dn_d_valid && dn_d_ready) d_hs++;
      @(posedge axi_aclk); #1;
      cyc++;
      if (a_hs >= v.exp_a) up_a_valid[v.m] = 1'b0;
      else if (a_hs >= 1 && stall_left > 0) begin
        up_a_valid[v.m] = 1'b0;
        stall_left--;
      end else up_a_valid[v.m] = 1'b1;
      up_a_data[v.m*CDW +: CDW] = exp_adata(v.m, a_hs);
      if (d_hs >= v.exp_d) dn_d_valid = 1'b0;
      dn_d_data = exp_ddata(d_hs);
      if (v.tog) up_d_ready[v.m] = ~up_d_ready[v.m];
    end
    check("a_beats", a_hs, v.exp_a);
    check("d_beats", d_hs, v.exp_d);
    check("arb_latency", first_a, 1);
    check("busy_after", busy, 0);
    check("sb_empty", sb.size(), 0);
    sb.delete();
    up_a_valid[v.m] = 1'b0;
    dn_d_valid = 1'b0;
  endtask

  // Both masters issue n single-beat Gets each, starting from ptr = 0.
  task automatic contention(input int n);
    int rem[2], r[2];
    int exp_ord[$];
    int p, sel, c, pend, pm, done, last_d, cyc, k;
    sb_t e;
    r[0] = n; r[1] = n; p = 0;
    for (int t = 0; t < 2*n; t++) begin
      sel = -1;
      for (int j = 0; j < 2; j++) begin
        c = (p + j) % 2;
        if (sel < 0 && r[c] > 0) sel = c;
      end
      exp_ord.push_back(sel);
      r[sel]--;
`ifndef TL_ARB_FIXED_PRIO_EN
      p = (sel + 1) % 2;
`endif
    end
    rem[0] = n; rem[1] = n;
    pend = 0; pm = 0; done = 0; last_d = -1; cyc = 0; k = 0;
    drive_a(0, 3'd4, 4'd2, 4'd1, 0);
    drive_a(1, 3'd4, 4'd2, 4'd2, 0);
    up_a_valid = 2'b11; dn_a_ready = 1'b1; up_d_ready = 2'b11; dn_d_valid = 1'b0;
    dn_d_opcode = 3'd1; dn_d_size = 4'd2;
    while (done < 2*n && cyc < 400) begin
      #1;
      for (int i = 0; i < NM; i++) begin
        if (up_d_valid[i] && up_d_ready[i]) begin
          if (sb.size() == 0) check("rr_sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            check("rr_d_master", i, e.m);
            check("rr_d_source", up_d_source[i*CIW +: CIW], e.src);
          end
        end
      end
      if (dn_d_valid && dn_d_ready) begin
        done++; pend = 0; last_d = cyc;
      end
      if (dn_a_valid && dn_a_ready) begin
        pm = int'(dn_a_source[CIW]);
        if (k < 2*n) begin
          check("rr_grant_order", pm, exp_ord[k]);
          sb.push_back('{m: exp_ord[k], src: 4'(exp_ord[k] + 1), op: 3'd1});
        end
        k++;
        if (rem[pm] > 0) rem[pm]--;
        pend = 1;
      end
      @(posedge axi_aclk); #1;
      cyc++;
      up_a_valid  = {rem[1] > 0, rem[0] > 0};
      dn_d_valid  = (pend != 0);
      dn_d_source = {1'(pm), 4'(pm + 1)};
    end
    check("rr_done", done, 2*n);
    check("rr_last_d_cycle", last_d, 6*n - 1);
    check("rr_sb_empty", sb.size(), 0);
    sb.delete();
    up_a_valid = '0;
    dn_d_valid = 1'b0;
  endtask

  initial begin
    int hs, cyc;
    vecs[0] = mk(0, 4, 2, 5, 1, 1);                       // Get size 2
    vecs[1] = mk(1, 0, 4, 3, 4, 1);                       // PutFull 16 B: 4 beats
    vecs[2] = mk(0, 0, 3, 9, 2, 1, 0, 1'b0, 3, 1'b1);     // stall after beat 1, m1 waiting
    vecs[3] = mk(1, 4, 2, 14, 1, 1);                      // the waiting m1 Get
    vecs[4] = mk(0, 1, 3, 2, 2, 1);                       // PutPartial 2 beats
    vecs[5] = mk(1, 4, 4, 7, 1, 4, 1, 1'b1);              // Get 4 beats, ready toggling
    vecs[6] = mk(0, 6, 5, 1, 1, 1);                       // other opcode: single beat
    vecs[7] = mk(1, 4, 0, 15, 1, 1, 1);                   // Get size 0
    vecs[8] = mk(0, 4, 2, 4, 1, 1, 1);                    // off-index response
    vecs[9] = mk(1, 0, 2, 8, 1, 1, 1);                    // PutFull single beat

    up_a_opcode = '0; up_a_param = '0; up_a_size = '0; up_a_source = '0;
    up_a_address = '0; up_a_mask = '0; up_a_data = '0; up_a_corrupt = '0;
    dn_d_opcode = '0; dn_d_param = '0; dn_d_size = '0; dn_d_source = '0;
    dn_d_denied = 1'b0; dn_d_data = '0; dn_d_corrupt = 1'b0;
    drive_a(0, 3'd4, 4'd2, 4'd1, 0);
    drive_a(1, 3'd4, 4'd2, 4'd2, 0);
    axi_aresetn = 1'b0;
    up_a_valid = 2'b11; dn_a_ready = 1'b1; up_d_ready = 2'b11; dn_d_valid = 1'b1;
    #12;
    check("rst_up_a_ready", up_a_ready, 0);
    check("rst_up_d_valid", up_d_valid, 0);
    check("rst_dn_a_valid", dn_a_valid, 0);
    check("rst_dn_d_ready", dn_d_ready, 0);
    check("rst_busy", busy, 0);
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    up_a_valid = '0;
    dn_d_valid = 1'b0;

    for (int v = 0; v < 10; v++) run_txn(vecs[v]);

    contention(4);

    // Leave ptr at 1, then abort a 4-beat Put from master 1 during beat 2.
    run_txn(vecs[0]);
    drive_a(1, 3'd0, 4'd4, 4'd3, 0);
    up_a_valid = 2'b10; dn_a_ready = 1'b1; up_d_ready = 2'b11; dn_d_valid = 1'b1;
    hs = 0; cyc = 0;
    while (hs == 0 && cyc < 10) begin
      #1;
      if (dn_a_valid && dn_a_ready) hs = 1;
      @(posedge axi_aclk); #1;
      cyc++;
    end
    check("abort_beat1", hs, 1);
    up_a_data[1*CDW +: CDW] = exp_adata(1, 1);
    #1;
    check("abort_beat2_valid", dn_a_valid, 1);
    axi_aresetn = 1'b0;
    #1;
    check("abort_dn_a_valid", dn_a_valid, 0);
    check("abort_up_a_ready", up_a_ready, 0);
    check("abort_dn_d_ready", dn_d_ready, 0);
    check("abort_up_d_valid", up_d_valid, 0);
    check("abort_busy", busy, 0);
    @(posedge axi_aclk); #1;
    check("abort_busy_held", busy, 0);
    axi_aresetn = 1'b1;
    up_a_valid = '0;
    dn_d_valid = 1'b0;
    sb.delete();

    // ptr must be back at 0: master 0 wins first in either mode.
    contention(1);
    run_txn(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tl_bridge_arbiter.md
# tl_bridge_arbiter

Round-robin arbiter that shares one TileLink-UL-to-AXI4 bridge port among NM TileLink masters. It sits between the masters and the bridge's master-side A/D channels and keeps exactly one transaction in flight. It grants one master and forwards that master's A beats. It then routes the bridge's D beats back to the same master and releases the grant after the final D beat. Downstream source IDs are widened with the master index so that responses can be traced.

## Interface
- NM, 2, number of upstream masters (2..8)
- CAW, 28, address width
- CDW, 32, data width (bytes per beat BPB = CDW/8)
- CIW, 4, upstream source width; downstream source width is CIW+MIW, where MIW = $clog2(NM)

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  reset; asynchronous assert, active-low
- up_a_opcode/param/size/source/address/mask/data/corrupt  in  NM×(3/3/4/CIW/CAW/BPB/CDW/1)  packed per-master A fields; master i occupies slice i
- up_a_valid  in  NM  per-master A valid
- up_a_ready  out  NM  per-master A ready
- up_d_opcode/param/size/source/denied/data/corrupt  out  NM×(3/2/4/CIW/1/CDW/1)  per-master D fields
- up_d_valid  out  NM  per-master D valid
- up_d_ready  in  NM  per-master D ready
- dn_a_*  out  single A channel to the bridge; dn_a_source is CIW+MIW wide, {grant index, up source}
- dn_a_valid  out  1; dn_a_ready  in  1
- dn_d_*  in  single D channel from the bridge; dn_d_source is CIW+MIW wide
- dn_d_valid  in  1; dn_d_ready  out  1
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- Beat count: beats(size) = 1 if 2^size ≤ BPB, otherwise 2^size / BPB.
- A beats expected: beats(size) for PutFullData (0) and PutPartialData (1); 1 for Get (4).
- D beats expected: beats(size) for Get (AccessAckData); 1 for Puts (AccessAck).
- Any other opcode is treated as a single-beat request with a single-beat response.
- FSM states are IDLE, A_PHASE and D_PHASE.
- IDLE:
  - If any up_a_valid is set, register grant = next requester at or after ptr (round-robin, wrapping modulo NM).
  - Latch the beat counts from the granted master's size/opcode and go to A_PHASE.
  - All up_a_ready are 0.
- A_PHASE:
  - dn_a_* mirrors the granted master's A fields. dn_a_valid = up_a_valid[grant] and up_a_ready[grant] = dn_a_ready. Other readies are 0.
  - The A counter decrements on each dn_a_valid&dn_a_ready. The accept of the final A beat moves the FSM to D_PHASE.
- D_PHASE:
  - up_d_valid[grant] = dn_d_valid and dn_d_ready = up_d_ready[grant].
  - up_d_source = dn_d_source[CIW-1:0]. All other up_d_valid are 0.
  - The D counter decrements per handshake. The final D handshake sets ptr = grant+1 (wrapping at NM) and returns to IDLE.
- Off-index responses: D beats whose dn_d_source[CIW+MIW-1:CIW] ≠ grant are still routed to grant (there is one outstanding transaction only). The mismatch is not flagged.
- Outside D_PHASE, dn_d_ready = 0.
- Reset values: FSM = IDLE, grant = 0, ptr = 0, counters = 0. All up_a_ready, up_d_valid, dn_a_valid and busy are 0; dn_d_ready is 0.
- Reset asserted mid-transaction aborts immediately. No partial beats are replayed.

## Timing
- Arbitration latency: 1 cycle from up_a_valid in IDLE to the first possible A handshake.
- A and D data paths are combinational pass-throughs (zero added latency) once the grant is registered.
- Minimum transaction occupancy is 1 (IDLE) + A beats + D beats cycles. Back-to-back transactions from different masters are separated by one IDLE cycle.
- A master that drops up_a_valid mid-burst stalls A_PHASE indefinitely. The grant is never revoked.
- A D beat arriving during A_PHASE is not accepted (dn_d_ready = 0) until D_PHASE.
- Requests arriving during A_PHASE or D_PHASE wait and are considered at the next IDLE.

## Configuration
- TL_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest-index valid master always wins and ptr is unused (held at 0).
  - Undefined: round-robin as described above.

## Test plan
- Single master 0, Get size 2 (CDW=32):
  - Arbitration: IDLE for 1 cycle, then 1 A beat.
  - Response: dn_d AccessAckData with dn_d_source = {0, src} → up_d_valid[0] for 1 beat; up_d_source = src; busy falls the cycle after the D handshake.
- Master 1, PutFullData size 4 (4 beats):
  - Ingress: 4 A beats forwarded, with dn_a_source upper bits = 1.
  - Response: one AccessAck → up_d_valid[1] only; master 0 sees no valid.
- Masters 0 and 1 both request continuously (4 Gets each):
  - Round-robin: grants alternate 0,1,0,1…
  - Fixed priority (TL_ARB_FIXED_PRIO_EN): grants 0,0,0,0 then 1.
- Get size 4, bridge holds dn_d_valid with up_d_ready[grant] toggled 1/0:
  - Exactly 4 D handshakes occur; the FSM returns to IDLE only after the 4th.
- axi_aresetn pulsed low during beat 2 of a 4-beat Put:
  - All valids and readies drop asynchronously; FSM = IDLE and ptr = 0.
  - A fresh Get after reset completes normally.
- Master drops up_a_valid after beat 1 of a 2-beat Put:
  - dn_a_valid = 0 and the grant is held; other masters are not granted until beat 2 and its AccessAck complete.
